icache_linefill_assembler: RTL and testbench

Collects narrow downstream read-data beats belonging to one MSHR refill and assembles them into a full 512-bit cache line. Presents each completed line, with its opcode, txnid and MSHR entry index, on a valid/ready interface that feeds the data-array controller's downstream_rxdat_* port. Double-buffered (ping-pong), so the next refill can be collected while the previous line waits to be written.

---
 rtl/icache_linefill_assembler_pkg.sv | 39 +++
 rtl/icache_linefill_assembler_if.sv | 41 ++++
 rtl/icache_linefill_assembler_buf.sv | 122 ++++++++++++
 rtl/icache_linefill_assembler.sv | 94 +++++++++
 tb/tb_icache_linefill_assembler.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_linefill_assembler_pkg.sv
// Shared widths, buffer state encoding and record types for the I-cache
// line-fill assembler and its ping-pong buffers.
package icache_linefill_assembler_pkg;

  function automatic int beat_id_width(input int beat_num);
    return (beat_num > 1) ? $clog2(beat_num) : 1;
  endfunction

  localparam int ICACHE_REQ_OPCODE_WIDTH      = 5;
  localparam int ICACHE_REQ_TXNID_WIDTH       = 8;
  localparam int MSHR_ENTRY_INDEX_WIDTH       = 4;
  localparam int ICACHE_DOWNSTREAM_DATA_WIDTH = 512;
  localparam int ICACHE_BEAT_WIDTH            = 128;
  localparam int ICACHE_LINE_BEAT_NUM         = ICACHE_DOWNSTREAM_DATA_WIDTH / ICACHE_BEAT_WIDTH;
  localparam int ICACHE_BEAT_ID_WIDTH         = beat_id_width(ICACHE_LINE_BEAT_NUM);

  typedef enum logic [1:0] {
    BUF_FREE    = 2'd0,
    BUF_FILLING = 2'd1,
    BUF_FULL    = 2'd2
  } linefill_buf_state_e;

  typedef struct packed {
    logic [ICACHE_REQ_OPCODE_WIDTH-1:0] opcode;
    logic [ICACHE_REQ_TXNID_WIDTH-1:0]  txnid;
    logic [MSHR_ENTRY_INDEX_WIDTH-1:0]  entry_idx;
  } linefill_meta_t;

  // Complete snapshot of one buffer in the default line geometry.
  typedef struct packed {
    linefill_buf_state_e                     state;
    logic [ICACHE_LINE_BEAT_NUM-1:0]         mask;
    logic [ICACHE_REQ_OPCODE_WIDTH-1:0]      opcode;
    logic [ICACHE_REQ_TXNID_WIDTH-1:0]       txnid;
    logic [MSHR_ENTRY_INDEX_WIDTH-1:0]       entry_idx;
    logic [ICACHE_DOWNSTREAM_DATA_WIDTH-1:0] data;
  } linefill_buf_t;

endpackage

// File: rtl/icache_linefill_assembler_if.sv
// Beat-in / line-out channels of the line-fill assembler. The slave modport is
// the assembler's view; the master modport is the surrounding bus and consumer.
interface icache_linefill_assembler_if #(
  parameter int BEAT_WIDTH    = icache_linefill_assembler_pkg::ICACHE_BEAT_WIDTH,
  parameter int LINE_WIDTH    = icache_linefill_assembler_pkg::ICACHE_DOWNSTREAM_DATA_WIDTH,
  parameter int BEAT_ID_WIDTH = icache_linefill_assembler_pkg::ICACHE_BEAT_ID_WIDTH
);
  import icache_linefill_assembler_pkg::*;

  logic                               bus_rxdat_vld;
  logic                               bus_rxdat_rdy;
  logic [ICACHE_REQ_OPCODE_WIDTH-1:0] bus_rxdat_opcode;
  logic [ICACHE_REQ_TXNID_WIDTH-1:0]  bus_rxdat_txnid;
  logic [MSHR_ENTRY_INDEX_WIDTH-1:0]  bus_rxdat_entry_idx;
  logic [BEAT_ID_WIDTH-1:0]           bus_rxdat_beat_id;
  logic [BEAT_WIDTH-1:0]              bus_rxdat_data;

  logic                               line_vld;
  logic                               line_rdy;
  logic [ICACHE_REQ_OPCODE_WIDTH-1:0] line_opcode;
  logic [ICACHE_REQ_TXNID_WIDTH-1:0]  line_txnid;
  logic [MSHR_ENTRY_INDEX_WIDTH-1:0]  line_entry_idx;
  logic [LINE_WIDTH-1:0]              line_data;

  modport slave (
    input  bus_rxdat_vld, bus_rxdat_opcode, bus_rxdat_txnid,
           bus_rxdat_entry_idx, bus_rxdat_beat_id, bus_rxdat_data,
    output bus_rxdat_rdy,
    output line_vld, line_opcode, line_txnid, line_entry_idx, line_data,
    input  line_rdy
  );

  modport master (
    output bus_rxdat_vld, bus_rxdat_opcode, bus_rxdat_txnid,
           bus_rxdat_entry_idx, bus_rxdat_beat_id, bus_rxdat_data,
    input  bus_rxdat_rdy,
    input  line_vld, line_opcode, line_txnid, line_entry_idx, line_data,
    output line_rdy
  );

endinterface

// File: rtl/icache_linefill_assembler_buf.sv
// One line-fill buffer: FREE/FILLING/FULL state machine, per-beat mask,
// captured meta and per-slot beat storage.
module icache_linefill_buf
  import icache_linefill_assembler_pkg::*;
#(
  parameter int BEAT_WIDTH    = ICACHE_BEAT_WIDTH,
  parameter int LINE_WIDTH    = ICACHE_DOWNSTREAM_DATA_WIDTH,
  parameter int BEAT_NUM      = LINE_WIDTH / BEAT_WIDTH,
  parameter int BEAT_ID_WIDTH = beat_id_width(BEAT_NUM)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  linefill_meta_t           wr_meta,
  input  logic [BEAT_ID_WIDTH-1:0] wr_beat_id,
  input  logic [BEAT_WIDTH-1:0]    wr_data,
  input  logic                     rd_ack,
  output linefill_buf_state_e      state,
  output linefill_meta_t           meta,
  output logic [LINE_WIDTH-1:0]    data,
  output logic                     fill_done,
  output logic                     beat_drop
);

  linefill_buf_state_e state_reg, state_next;
  logic [BEAT_NUM-1:0] mask_reg, mask_next;
  logic [BEAT_NUM-1:0] beat_sel;
  logic [BEAT_NUM-1:0] slot_wr;
  linefill_meta_t      meta_reg;
  logic                meta_wr;

  // One-hot slot select; an out-of-range beat_id selects nothing.
  for (genvar gi = 0; gi < BEAT_NUM; gi++) begin : g_sel
    assign beat_sel[gi] = (wr_beat_id == BEAT_ID_WIDTH'(gi));
  end

  always_comb begin
    state_next = state_reg;
    mask_next  = mask_reg;
    slot_wr    = '0;
    meta_wr    = 1'b0;
    fill_done  = 1'b0;
    beat_drop  = 1'b0;
    case (state_reg)
      BUF_FREE: begin
        if (wr_en) begin
          if (beat_sel == '0) begin
            beat_drop = 1'b1;
          end else begin
            meta_wr   = 1'b1;
            slot_wr   = beat_sel;
            mask_next = beat_sel;
            if (&beat_sel) begin
              state_next = BUF_FULL;
              fill_done  = 1'b1;
            end else begin
              state_next = BUF_FILLING;
            end
          end
        end
      end
      BUF_FILLING: begin
        if (wr_en) begin
          // Foreign entry or already-filled slot: consume the beat, keep the old data.
          if ((beat_sel == '0) || (wr_meta.entry_idx != meta_reg.entry_idx) ||
              ((mask_reg & beat_sel) != '0)) begin
            beat_drop = 1'b1;
          end else begin
            slot_wr   = beat_sel;
            mask_next = mask_reg | beat_sel;
            if (&mask_next) begin
              state_next = BUF_FULL;
              fill_done  = 1'b1;
            end
          end
        end
      end
      BUF_FULL: begin
        if (rd_ack) begin
          state_next = BUF_FREE;
          mask_next  = '0;
        end
      end
      default: begin
        state_next = BUF_FREE;
        mask_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= BUF_FREE;
      mask_reg  <= '0;
      meta_reg  <= '0;
    end else begin
      state_reg <= state_next;
      mask_reg  <= mask_next;
      if (meta_wr) begin
        meta_reg <= wr_meta;
      end
    end
  end

  for (genvar gi = 0; gi < BEAT_NUM; gi++) begin : g_slot
    logic [BEAT_WIDTH-1:0] slot_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_reg <= '0;
      end else if (slot_wr[gi]) begin
        slot_reg <= wr_data;
      end
    end

    assign data[gi*BEAT_WIDTH +: BEAT_WIDTH] = slot_reg;
  end

  assign state = state_reg;
  assign meta  = meta_reg;

endmodule

// File: rtl/icache_linefill_assembler.sv
// Ping-pong line-fill assembler: beats fill buf[fill_ptr] while buf[rd_ptr]
// presents its completed line to the data-array controller.
module icache_linefill_assembler
  import icache_linefill_assembler_pkg::*;
#(
  parameter int BEAT_WIDTH    = ICACHE_BEAT_WIDTH,
  parameter int LINE_WIDTH    = ICACHE_DOWNSTREAM_DATA_WIDTH,
  parameter int BEAT_NUM      = LINE_WIDTH / BEAT_WIDTH,
  parameter int BEAT_ID_WIDTH = beat_id_width(BEAT_NUM)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  icache_linefill_assembler_if.slave bus,
  output logic                       asm_err
);

  localparam int BUF_NUM = 2;

  linefill_buf_state_e   buf_state [BUF_NUM];
  linefill_meta_t        buf_meta  [BUF_NUM];
  logic [LINE_WIDTH-1:0] buf_data  [BUF_NUM];
  logic [BUF_NUM-1:0]    buf_wr_en;
  logic [BUF_NUM-1:0]    buf_rd_ack;
  logic [BUF_NUM-1:0]    buf_fill_done;
  logic [BUF_NUM-1:0]    buf_beat_drop;

  logic           fill_ptr_reg, fill_ptr_next;
  logic           rd_ptr_reg, rd_ptr_next;
  logic           asm_err_reg, asm_err_next;
  logic           beat_acc;
  logic           line_hs;
  linefill_meta_t beat_meta;

  assign beat_meta = '{opcode:    bus.bus_rxdat_opcode,
                       txnid:     bus.bus_rxdat_txnid,
                       entry_idx: bus.bus_rxdat_entry_idx};

  // Both handshakes depend only on registered buffer state, never on line_rdy.
  assign bus.bus_rxdat_rdy = (buf_state[fill_ptr_reg] != BUF_FULL);
  assign beat_acc          = bus.bus_rxdat_vld && bus.bus_rxdat_rdy;

  assign bus.line_vld       = (buf_state[rd_ptr_reg] == BUF_FULL);
  assign line_hs            = bus.line_vld && bus.line_rdy;
  assign bus.line_opcode    = buf_meta[rd_ptr_reg].opcode;
  assign bus.line_txnid     = buf_meta[rd_ptr_reg].txnid;
  assign bus.line_entry_idx = buf_meta[rd_ptr_reg].entry_idx;
  assign bus.line_data      = buf_data[rd_ptr_reg];

  for (genvar gi = 0; gi < BUF_NUM; gi++) begin : g_buf
    assign buf_wr_en[gi]  = beat_acc && (fill_ptr_reg == 1'(gi));
    assign buf_rd_ack[gi] = line_hs && (rd_ptr_reg == 1'(gi));

    icache_linefill_buf #(
      .BEAT_WIDTH    (BEAT_WIDTH),
      .LINE_WIDTH    (LINE_WIDTH),
      .BEAT_NUM      (BEAT_NUM),
      .BEAT_ID_WIDTH (BEAT_ID_WIDTH)
    ) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (buf_wr_en[gi]),
      .wr_meta    (beat_meta),
      .wr_beat_id (bus.bus_rxdat_beat_id),
      .wr_data    (bus.bus_rxdat_data),
      .rd_ack     (buf_rd_ack[gi]),
      .state      (buf_state[gi]),
      .meta       (buf_meta[gi]),
      .data       (buf_data[gi]),
      .fill_done  (buf_fill_done[gi]),
      .beat_drop  (buf_beat_drop[gi])
    );
  end

  always_comb begin
    fill_ptr_next = fill_ptr_reg ^ (|buf_fill_done);
    rd_ptr_next   = rd_ptr_reg ^ line_hs;
    asm_err_next  = |buf_beat_drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_ptr_reg <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      asm_err_reg  <= 1'b0;
    end else begin
      fill_ptr_reg <= fill_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      asm_err_reg  <= asm_err_next;
    end
  end

  assign asm_err = asm_err_reg;

endmodule

// File: tb/tb_icache_linefill_assembler.sv
// Scoreboard bench for icache_linefill_assembler: directed scenarios plus
// randomized refills with injected duplicate and foreign beats.
module tb_icache_linefill_assembler;
  import icache_linefill_assembler_pkg::*;

  localparam int BW = ICACHE_BEAT_WIDTH;
  localparam int LW = ICACHE_DOWNSTREAM_DATA_WIDTH;
  localparam int BN = ICACHE_LINE_BEAT_NUM;

  typedef logic [LW-1:0]                      wide_t;
  typedef logic [MSHR_ENTRY_INDEX_WIDTH-1:0]  entry_t;
  typedef logic [ICACHE_REQ_TXNID_WIDTH-1:0]  txnid_t;
  typedef logic [ICACHE_REQ_OPCODE_WIDTH-1:0] opcode_t;
  typedef logic [ICACHE_BEAT_ID_WIDTH-1:0]    beat_id_t;
  typedef logic [BW-1:0]                      beat_t;

  typedef struct {
    entry_t  entry;
    txnid_t  txnid;
    opcode_t opcode;
    wide_t   data;
  } exp_line_t;

  logic clk = 1'b0;
  logic rst_n;
  logic asm_err;

  icache_linefill_assembler_if intf ();

  icache_linefill_assembler dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (intf),
    .asm_err (asm_err)
  );

  always #5 clk = ~clk;

  exp_line_t exp_q[$];
  int        tests = 0;
  int        fails = 0;
  int        err_seen = 0;
  int        err_exp = 0;
  int        rdy_mode = 0;  // 0: line_rdy driven by main flow, 1: always, 2: random
  beat_t     txn_data [BN];
  int        txn_order [BN];

  task automatic check(input string name, input wide_t act, input wide_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t rand_beat();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) intf.line_rdy = 1'b1;
      else if (rdy_mode == 2) intf.line_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: counts error pulses, checks hold stability, pops on each line handshake.
  initial begin
    logic    held;
    entry_t  h_entry;
    txnid_t  h_txnid;
    opcode_t h_opcode;
    wide_t   h_data;
    exp_line_t e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (asm_err === 1'b1) err_seen++;
      if (held && intf.line_vld) begin
        check("hold_meta", wide_t'({intf.line_entry_idx, intf.line_txnid, intf.line_opcode}),
              wide_t'({h_entry, h_txnid, h_opcode}));
        check("hold_data", intf.line_data, h_data);
      end
      held     = intf.line_vld && !intf.line_rdy;
      h_entry  = intf.line_entry_idx;
      h_txnid  = intf.line_txnid;
      h_opcode = intf.line_opcode;
      h_data   = intf.line_data;
      if (intf.line_vld && intf.line_rdy) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_line: got entry %0h txnid %0h, expected no line",
                   intf.line_entry_idx, intf.line_txnid);
        end else begin
          e = exp_q.pop_front();
          check("line_meta", wide_t'({intf.line_entry_idx, intf.line_txnid, intf.line_opcode}),
                wide_t'({e.entry, e.txnid, e.opcode}));
          check("line_data", intf.line_data, e.data);
          $display("[TB] line entry=%0h txnid=%0h opcode=%0h", intf.line_entry_idx,
                   intf.line_txnid, intf.line_opcode);
        end
      end
    end
  end

  task automatic send_beat(input entry_t e, input txnid_t t, input opcode_t op,
                           input beat_id_t b, input beat_t d);
    int waited;
    waited = 0;
    intf.bus_rxdat_vld       = 1'b1;
    intf.bus_rxdat_entry_idx = e;
    intf.bus_rxdat_txnid     = t;
    intf.bus_rxdat_opcode    = op;
    intf.bus_rxdat_beat_id   = b;
    intf.bus_rxdat_data      = d;
    @(negedge clk);
    while (!intf.bus_rxdat_rdy && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!intf.bus_rxdat_rdy) begin
      tests++;
      fails++;
      $display("FAIL beat_accept_timeout: got rdy=0 for 200 cycles, expected rdy=1");
    end
    @(posedge clk);
    #1;
    intf.bus_rxdat_vld = 1'b0;
  endtask

  // Expected line is the first-written data of every slot, assembled slot3..slot0.
  task automatic run_txn(input entry_t e, input txnid_t t, input opcode_t op,
                         input int dup_at, input int dup_beat, input int mis_at);
    exp_line_t x;
    x.entry  = e;
    x.txnid  = t;
    x.opcode = op;
    for (int i = 0; i < BN; i++) x.data[i*BW +: BW] = txn_data[i];
    exp_q.push_back(x);
    for (int k = 0; k < BN; k++) begin
      if (k == mis_at) begin
        send_beat(entry_t'(e + entry_t'(1)), txnid_t'($urandom()), op,
                  beat_id_t'($urandom_range(0, BN - 1)), rand_beat());
        err_exp++;
      end
      if (k == dup_at) begin
        send_beat(e, t, op, beat_id_t'(dup_beat), rand_beat());
        err_exp++;
      end
      send_beat(e, t, op, beat_id_t'(txn_order[k]), txn_data[txn_order[k]]);
    end
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    rdy_mode = 1;
    while (exp_q.size() != 0 && waited < 300) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d lines pending, expected 0", exp_q.size());
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_order_inline();
    for (int i = 0; i < BN; i++) txn_order[i] = i;
  endtask

  task automatic shuffle_order();
    int j, tmp;
    set_order_inline();
    for (int i = BN - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = txn_order[i];
      txn_order[i] = txn_order[j];
      txn_order[j] = tmp;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int dup_at, dup_beat, mis_at;
    rst_n                    = 1'b0;
    intf.bus_rxdat_vld       = 1'b0;
    intf.bus_rxdat_entry_idx = '0;
    intf.bus_rxdat_txnid     = '0;
    intf.bus_rxdat_opcode    = '0;
    intf.bus_rxdat_beat_id   = '0;
    intf.bus_rxdat_data      = '0;
    intf.line_rdy            = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_bus_rdy", wide_t'(intf.bus_rxdat_rdy), wide_t'(1'b1));
    check("rst_line_vld", wide_t'(intf.line_vld), wide_t'(1'b0));
    check("rst_asm_err", wide_t'(asm_err), wide_t'(1'b0));
    check("rst_line_meta", wide_t'({intf.line_entry_idx, intf.line_txnid, intf.line_opcode}), '0);
    check("rst_line_data", intf.line_data, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Test 1: in-order beats, one-cycle latency to line_vld.
    rdy_mode = 0;
    intf.line_rdy = 1'b0;
    for (int i = 0; i < BN; i++) txn_data[i] = {32{4'(i)}};
    begin
      exp_line_t x;
      x.entry = entry_t'(3);
      x.txnid = txnid_t'(8'h15);
      x.opcode = opcode_t'(5'h04);
      for (int i = 0; i < BN; i++) x.data[i*BW +: BW] = txn_data[i];
      exp_q.push_back(x);
    end
    for (int k = 0; k < BN; k++) begin
      send_beat(entry_t'(3), txnid_t'(8'h15), opcode_t'(5'h04), beat_id_t'(k), txn_data[k]);
      if (k == BN - 2) check("latency_before", wide_t'(intf.line_vld), wide_t'(1'b0));
      if (k == BN - 1) check("latency_after", wide_t'(intf.line_vld), wide_t'(1'b1));
    end
    drain();

    // Test 2: out-of-order beat ids 2,0,3,1.
    txn_order[0] = 2; txn_order[1] = 0; txn_order[2] = 3; txn_order[3] = 1;
    for (int i = 0; i < BN; i++) txn_data[i] = rand_beat();
    run_txn(entry_t'(9), txnid_t'(8'h2a), opcode_t'(5'h01), -1, 0, -1);
    drain();

    // Test 3: both buffers full back-pressure the beat bus.
    rdy_mode = 0;
    intf.line_rdy = 1'b0;
    set_order_inline();
    for (int i = 0; i < BN; i++) txn_data[i] = rand_beat();
    run_txn(entry_t'(1), txnid_t'(8'h31), opcode_t'(5'h02), -1, 0, -1);
    for (int i = 0; i < BN; i++) txn_data[i] = rand_beat();
    run_txn(entry_t'(2), txnid_t'(8'h32), opcode_t'(5'h02), -1, 0, -1);
    @(negedge clk);
    check("both_full_rdy", wide_t'(intf.bus_rxdat_rdy), wide_t'(1'b0));
    @(posedge clk);
    #1;
    intf.line_rdy = 1'b1;
    @(negedge clk);
    check("rdy_same_cycle", wide_t'(intf.bus_rxdat_rdy), wide_t'(1'b0));
    @(posedge clk);
    #1;
    intf.line_rdy = 1'b0;
    @(negedge clk);
    check("rdy_next_cycle", wide_t'(intf.bus_rxdat_rdy), wide_t'(1'b1));
    @(posedge clk);
    #1;
    rdy_mode = 2;
    for (int i = 0; i < BN; i++) txn_data[i] = rand_beat();
    run_txn(entry_t'(4), txnid_t'(8'h34), opcode_t'(5'h02), -1, 0, -1);
    drain();

    // Test 4: duplicate beat 1 is dropped with one error pulse.
    base = err_seen;
    set_order_inline();
    for (int i = 0; i < BN; i++) txn_data[i] = rand_beat();
    run_txn(entry_t'(6), txnid_t'(8'h40), opcode_t'(5'h03), 2, 1, -1);
    drain();
    check("dup_err_pulse", wide_t'(err_seen - base), wide_t'(1));

    // Test 5: foreign-entry beat mid-fill is dropped with one error pulse.
    base = err_seen;
    for (int i = 0; i < BN; i++) txn_data[i] = rand_beat();
    run_txn(entry_t'(5), txnid_t'(8'h50), opcode_t'(5'h03), -1, 0, 1);
    drain();
    check("mismatch_err_pulse", wide_t'(err_seen - base), wide_t'(1));

    // Test 6: reset mid-fill discards the partial line.
    rdy_mode = 0;
    intf.line_rdy = 1'b0;
    send_beat(entry_t'(7), txnid_t'(8'h70), opcode_t'(5'h05), beat_id_t'(0), rand_beat());
    send_beat(entry_t'(7), txnid_t'(8'h70), opcode_t'(5'h05), beat_id_t'(1), rand_beat());
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_line_vld", wide_t'(intf.line_vld), wide_t'(1'b0));
    check("midrst_bus_rdy", wide_t'(intf.bus_rxdat_rdy), wide_t'(1'b1));
    check("midrst_line_data", intf.line_data, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    shuffle_order();
    for (int i = 0; i < BN; i++) txn_data[i] = rand_beat();
    run_txn(entry_t'(2), txnid_t'(8'h62), opcode_t'(5'h06), -1, 0, -1);
    drain();

    // Randomized refills with random consumer back-pressure.
    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      shuffle_order();
      for (int i = 0; i < BN; i++) txn_data[i] = rand_beat();
      dup_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, BN - 1)) : -1;
      dup_beat = (dup_at > 0) ? txn_order[$urandom_range(0, dup_at - 1)] : 0;
      mis_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, BN - 1)) : -1;
      run_txn(entry_t'($urandom()), txnid_t'($urandom()), opcode_t'($urandom()),
              dup_at, dup_beat, mis_at);
      rdy_mode = 2;
    end
    drain();

    check("err_total", wide_t'(err_seen), wide_t'(err_exp));
    check("queue_empty", wide_t'(exp_q.size()), wide_t'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
